// File: rtl/serial_receiver.sv
// 8N1 serial receive path: two-flop line synchroniser, mid-bit sampling FSM and a
// valid/ready holding register for the received byte, with framing-error and overrun pulses.
module serial_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  output logic [7:0] bus,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    bus_q, bus_d;
  logic          bus_valid_q, bus_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          sync1_q, sync2_q;
  logic          line_s;
  logic          complete;

  assign line_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    bus_d       = bus_q;
    bus_valid_d = bus_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    // cnt restarts at every sample point so each sample lands mid-bit
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!line_s) begin
            state_d   = DATA;
            bit_idx_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d                    = '0;
          shreg_d[bit_idx_q[2:0]]  = line_s;
          bit_idx_d                = bit_idx_q + 1'b1;
          if (bit_idx_q == 4'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line_s) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (line_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A finished byte is dropped, not overwritten, while the consumer still holds the old one
    if (complete) begin
      if (!bus_valid_q || bus_ready) begin
        bus_d       = shreg_q;
        bus_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus_valid_q && bus_ready) begin
      bus_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 4'd0;
      shreg_q     <= 8'h00;
      bus_q       <= 8'h00;
      bus_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= data;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: a table of framed bytes plus hand-written
// glitch, overrun and mid-frame reset sequences, all at 16 clk per bit.
module tb_serial_receiver;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic [7:0] bus;
  logic       bus_valid;
  logic       bus_ready;
  logic       frame_err;
  logic       overrun;

  serial_receiver #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .bus       (bus),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic       ready;
    int         low_hold;
    int         gap;
    int         exp_acc;
    logic [7:0] exp_byte;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs [5];

  int         vectors;
  int         miscompares;
  int         cycle_cnt;
  int         frame_start;
  int         rise_cycle;
  int         acc_cnt;
  int         ferr_cnt;
  int         ovr_cnt;
  int         both_cnt;
  logic [7:0] last_acc;
  logic       prev_valid;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Observe handshakes and pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (bus_valid && bus_ready) begin
        acc_cnt++;
        last_acc = bus;
      end
      if (bus_valid && !prev_valid) rise_cycle = cycle_cnt;
      prev_valid = bus_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic clear_counts();
    acc_cnt    = 0;
    ferr_cnt   = 0;
    ovr_cnt    = 0;
    rise_cycle = -1;
  endtask

  task automatic drive_bit(input logic v);
    data = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_start = cycle_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_cycles(input logic v, input int n);
    data = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clear_counts();
    bus_ready = v.ready;
    send_frame(v.tx, v.stop);
    if (v.low_hold > 0) idle_cycles(1'b0, v.low_hold);
    if (v.gap > 0) idle_cycles(1'b1, v.gap);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle_cnt   = 0;
    both_cnt    = 0;
    prev_valid  = 1'b0;
    last_acc    = 8'h00;
    clear_counts();

    // tx, stop, ready, low_hold, gap, exp_acc, exp_byte, exp_ferr, exp_ovr
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0,  10, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0,  0,  1, 8'h00, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0,  10, 1, 8'hFF, 0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 40, 10, 0, 8'h00, 1, 0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 0,  10, 1, 8'h81, 0, 0};

    data      = 1'b1;
    bus_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bus", int'(bus), 0);
    checkOutput("reset_valid", int'(bus_valid), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    idle_cycles(1'b1, 5);

    // Low glitch shorter than half a bit must be rejected silently
    clear_counts();
    idle_cycles(1'b0, 4);
    idle_cycles(1'b1, 30);
    checkOutput("glitch_valid_cycles", acc_cnt, 0);
    checkOutput("glitch_frame_err", ferr_cnt, 0);
    checkOutput("glitch_overrun", ovr_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_accepted", i), acc_cnt, vecs[i].exp_acc);
      if (vecs[i].exp_acc > 0) begin
        checkOutput($sformatf("v%0d_byte", i), int'(last_acc), int'(vecs[i].exp_byte));
        checkOutput($sformatf("v%0d_latency", i), rise_cycle - frame_start, 155);
      end
      checkOutput($sformatf("v%0d_frame_err", i), ferr_cnt, vecs[i].exp_ferr);
      checkOutput($sformatf("v%0d_overrun", i), ovr_cnt, vecs[i].exp_ovr);
      checkOutput($sformatf("v%0d_valid_end", i), int'(bus_valid), 0);
    end

    // Consumer stalled: first byte held, second byte dropped with an overrun pulse
    clear_counts();
    bus_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_cycles(1'b1, 10);
    checkOutput("ovr_first_valid", int'(bus_valid), 1);
    checkOutput("ovr_first_bus", int'(bus), 8'h11);
    checkOutput("ovr_first_flag", ovr_cnt, 0);
    send_frame(8'h22, 1'b1);
    idle_cycles(1'b1, 10);
    checkOutput("ovr_second_flag", ovr_cnt, 1);
    checkOutput("ovr_second_bus", int'(bus), 8'h11);
    checkOutput("ovr_second_valid", int'(bus_valid), 1);
    checkOutput("ovr_frame_err", ferr_cnt, 0);
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ovr_release_valid", int'(bus_valid), 0);
    checkOutput("ovr_release_bus", int'(bus), 8'h11);
    checkOutput("ovr_release_acc", acc_cnt, 1);
    checkOutput("ovr_release_byte", int'(last_acc), 8'h11);

    // Reset in the middle of data bit 4 of 8'h5A
    clear_counts();
    begin
      logic [7:0] partial;
      partial = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(partial[i]);
      data = partial[4];
      repeat (8) @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_bus", int'(bus), 0);
    checkOutput("midrst_valid", int'(bus_valid), 0);
    checkOutput("midrst_frame_err", int'(frame_err), 0);
    checkOutput("midrst_overrun", int'(overrun), 0);
    data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1'b1, 40);
    checkOutput("midrst_no_load", acc_cnt, 0);
    clear_counts();
    send_frame(8'hC3, 1'b1);
    idle_cycles(1'b1, 10);
    checkOutput("after_rst_acc", acc_cnt, 1);
    checkOutput("after_rst_byte", int'(last_acc), 8'hC3);
    checkOutput("after_rst_latency", rise_cycle - frame_start, 155);
    checkOutput("after_rst_frame_err", ferr_cnt, 0);
    checkOutput("flags_together", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
